aggr_par_sched: RTL and testbench
=================================

Name: aggr_par_sched

Overview:
- Weighted round-robin scheduler that shares one downstream aggregated-parser metadata FIFO among NPORTS upstream sfifo_aggr_par instances.
- Each upstream FIFO presents its first-word-fall-through dout plus empty. The scheduler issues at most one pop per cycle and forwards the popped word, tagged with its source port, as a write into the downstream FIFO.
- Per-port weights (burst quanta) and per-port pop counters are reachable through a simple register interface.

Parameters:
- NPORTS, 4, number of upstream requesters (power of two, 2..8).
- PORT_NBITS, 2, log2(NPORTS).
- WT_NBITS, 4, width of a per-port weight.
- STAT_NBITS, 16, width of a per-port saturating pop counter.

Ports:
- clk  in  1  single clock, all logic on posedge.
- `RESET_SIG  in  1  codebase reset signal; asynchronous, active-high.
- in_empty  in  NPORTS  per-port upstream FIFO empty.
- in_data  in  NPORTS x aggr_par_meta_type  per-port upstream dout, valid when ~in_empty.
- in_rd  out  NPORTS  per-port pop strobe, one-hot or zero.
- out_full  in  1  downstream FIFO full (registered).
- out_wr  out  1  downstream write strobe.
- out_data  out  aggr_par_meta_type  word written downstream.
- out_port  out  PORT_NBITS  source port of out_data.
- cfg_wr  in  1  register write strobe.
- cfg_rd  in  1  register read strobe.
- cfg_addr  in  PORT_NBITS+1  bit MSB=0 selects weight[port]; MSB=1 selects stat[port].
- cfg_wdata  in  STAT_NBITS  write data; weight uses the low WT_NBITS bits.
- cfg_rdata  out  STAT_NBITS  read data, one cycle after cfg_rd.

Behaviour:
- Reset values: in_rd=0, out_wr=0, out_data=0, out_port=0, cfg_rdata=0, cur_port=0, burst_cnt=0, all stats=0, all weights=1.
- Eligibility: port p is eligible iff ~in_empty[p] & weight[p]!=0. Weight 0 disables the port.
- Serve rule, combinational within a cycle, gated by ~out_full:
  - Current port keeps the grant if eligible and burst_cnt < weight[cur_port].
  - Otherwise grant the first eligible port scanning cur_port+1, cur_port+2, ... with wrap modulo NPORTS. The current port is scanned last.
- Switching costs no idle cycle.
- On a grant to port g:
  - in_rd[g]=1 in the same cycle (combinational).
  - Registered outputs next cycle: out_wr=1, out_data=in_data[g], out_port=g. Latency from pop to downstream write is 1 cycle.
  - If g==cur_port and the grant is a keep, burst_cnt increments. If g is a new port, cur_port<=g and burst_cnt<=1.
- No eligible port, or out_full=1: no pop; out_wr<=0; cur_port and burst_cnt hold.
- out_full is registered and already includes the previous cycle's write, so gating on out_full alone never overflows.
- With out_full=1 and the current burst unfinished, the burst resumes on the same port when space returns.
- Weight rewrite mid-burst takes effect next cycle. If burst_cnt >= new weight, the port is treated as exhausted.
- Stats: stat[g] increments on each pop and saturates at all-ones. A cfg_wr to a stat address clears it. A pop and a clear in the same cycle leave stat=1.
- cfg_wr and cfg_rd to the same address in the same cycle: cfg_rdata returns the pre-write value.
- The downstream write and the upstream pop never occur on the same cycle for the same word. An upstream empty rising after a pop is naturally respected because in_empty is registered upstream.
- Diagnostics (translate_off): flag in_rd[p] while in_empty[p], flag out_wr while out_full, flag in_rd that is not one-hot.

Decomposition:
- meta_package gains the constants AGGR_SCHED_NPORTS and AGGR_SCHED_WT_NBITS. aggr_par_meta_type is reused unchanged.
- Sub-module rr_pick (NPORTS): inputs req vector and base index; outputs one-hot grant plus encoded index. Finds the first set bit after base with wrap. Generic and reusable by other schedulers.

Test Plan:
- Weights all 1, all four ports holding 3 words, out_full=0 -> out_port sequence 0,1,2,3,0,1,2,3,0,1,2,3; first out_wr one cycle after first in_rd.
- weight={3,1,1,1}, all ports backlogged -> pattern 0,0,0,1,2,3 repeating; stat[0] reads 3x stat[1] after 24 pops.
- Only port 2 non-empty with 5 words, weight 2 -> 5 back-to-back pops from port 2, no idle cycles.
- out_full asserted for 4 cycles mid-burst -> in_rd=0 and out_wr=0 during the stall; burst resumes on the same port; no word lost or duplicated (scoreboard).
- weight[1]=0 with port 1 non-empty -> port 1 never popped; writing weight 1 makes it served within NPORTS grants.
- Reset asserted mid-stream -> all outputs 0 asynchronously; after release, weights=1, stats=0, arbitration restarts from port 0.

Source files
------------

// File: rtl/aggr_par_sched_pkg.sv
// Shared types and constants for the aggregated-parser
// metadata scheduler.
package aggr_par_sched_pkg;

  localparam int AGGR_SCHED_NPORTS   = 4;
  localparam int AGGR_SCHED_WT_NBITS = 4;

  typedef struct packed {
    logic [15:0] pkt_len;
    logic [7:0]  hdr_off;
    logic [7:0]  proto;
  } aggr_par_meta_type;

endpackage

// File: rtl/aggr_par_sched_pick.sv
// Round-robin picker: first requester after base,
// wrapping, with base itself scanned last.
module rr_pick #(
  parameter int NPORTS    = 4,
  parameter int IDX_NBITS = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0]    req_i,
  input  logic [IDX_NBITS-1:0] base_i,
  output logic [NPORTS-1:0]    gnt_o,
  output logic [IDX_NBITS-1:0] idx_o,
  output logic                 vld_o
);

  logic [IDX_NBITS-1:0] cand;

  // scan farthest offset first so the nearest one wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int i = NPORTS; i >= 1; i--) begin
      cand = base_i + IDX_NBITS'(i);
      if (req_i[cand]) begin
        idx_o = cand;
        vld_o = 1'b1;
      end
    end
    if (vld_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/aggr_par_sched.sv
// Weighted round-robin pop scheduler feeding one
// downstream metadata FIFO from NPORTS upstream FIFOs.
module aggr_par_sched
  import aggr_par_sched_pkg::*;
#(
  parameter int NPORTS     = AGGR_SCHED_NPORTS,
  parameter int PORT_NBITS = 2,
  parameter int WT_NBITS   = AGGR_SCHED_WT_NBITS,
  parameter int STAT_NBITS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NPORTS-1:0]             in_empty,
  input  aggr_par_meta_type [NPORTS-1:0] in_data,
  output logic [NPORTS-1:0]             in_rd,
  input  logic                          out_full,
  output logic                          out_wr,
  output aggr_par_meta_type             out_data,
  output logic [PORT_NBITS-1:0]         out_port,
  input  logic                          cfg_wr,
  input  logic                          cfg_rd,
  input  logic [PORT_NBITS:0]           cfg_addr,
  input  logic [STAT_NBITS-1:0]         cfg_wdata,
  output logic [STAT_NBITS-1:0]         cfg_rdata
);

  logic [WT_NBITS-1:0]   weight_q [NPORTS];
  logic [STAT_NBITS-1:0] stat_q   [NPORTS];
  logic [PORT_NBITS-1:0] cur_q, cur_d;
  logic [WT_NBITS-1:0]   burst_q, burst_d;
  logic [NPORTS-1:0]     elig, pick_gnt, cur_oh;
  logic [PORT_NBITS-1:0] pick_idx, gnt_idx;
  logic                  pick_vld, keep, grant;
  logic [PORT_NBITS-1:0] cfg_port;
  logic                  cfg_stat;
  logic                  unused_wdata;

  assign cfg_port     = cfg_addr[PORT_NBITS-1:0];
  assign cfg_stat     = cfg_addr[PORT_NBITS];
  assign unused_wdata = ^cfg_wdata[STAT_NBITS-1:WT_NBITS];

  // a zero weight parks the port
  always_comb begin
    elig = '0;
    for (int p = 0; p < NPORTS; p++)
      elig[p] = ~in_empty[p] & (weight_q[p] != '0);
  end

  rr_pick #(
    .NPORTS   (NPORTS),
    .IDX_NBITS(PORT_NBITS)
  ) u_pick (
    .req_i (elig),
    .base_i(cur_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // keep the burst while quota remains, else move on
  always_comb begin
    cur_oh  = NPORTS'(1) << cur_q;
    keep    = elig[cur_q] & (burst_q < weight_q[cur_q]);
    grant   = ~rst & ~out_full & (keep | pick_vld);
    gnt_idx = keep ? cur_q : pick_idx;
    in_rd   = '0;
    cur_d   = cur_q;
    burst_d = burst_q;
    if (grant) begin
      in_rd   = keep ? cur_oh : pick_gnt;
      cur_d   = gnt_idx;
      burst_d = keep ? burst_q + WT_NBITS'(1)
                     : WT_NBITS'(1);
    end
  end

  // arbitration state and registered downstream write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q    <= '0;
      burst_q  <= '0;
      out_wr   <= 1'b0;
      out_data <= '0;
      out_port <= '0;
    end else begin
      cur_q   <= cur_d;
      burst_q <= burst_d;
      out_wr  <= grant;
      if (grant) begin
        out_data <= in_data[gnt_idx];
        out_port <= gnt_idx;
      end
    end
  end

  // weights, saturating pop counters and read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rdata <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        weight_q[p] <= WT_NBITS'(1);
        stat_q[p]   <= '0;
      end
    end else begin
      if (cfg_rd)
        cfg_rdata <= cfg_stat ? stat_q[cfg_port]
                   : STAT_NBITS'(weight_q[cfg_port]);
      for (int p = 0; p < NPORTS; p++) begin
        if (cfg_wr & ~cfg_stat &
            (cfg_port == PORT_NBITS'(p)))
          weight_q[p] <= cfg_wdata[WT_NBITS-1:0];
        if (cfg_wr & cfg_stat &
            (cfg_port == PORT_NBITS'(p)))
          stat_q[p] <= in_rd[p] ? STAT_NBITS'(1) : '0;
        else if (in_rd[p] && (stat_q[p] != '1))
          stat_q[p] <= stat_q[p] + STAT_NBITS'(1);
      end
    end
  end

`ifndef SYNTHESIS
  a_rd_empty: assert property (
    @(posedge clk) disable iff (rst)
    (in_rd & in_empty) == '0);
  a_rd_onehot: assert property (
    @(posedge clk) disable iff (rst)
    $onehot0(in_rd));
  a_wr_full: assert property (
    @(posedge clk) disable iff (rst)
    out_wr |-> !$past(out_full));
`endif

endmodule

// File: tb/tb_aggr_par_sched.sv
// Scoreboard bench for aggr_par_sched: upstream FIFOs are
// queues, expected writes are queued as stimulus is loaded.
module tb_aggr_par_sched;
  import aggr_par_sched_pkg::*;

  localparam int NP = 4;
  localparam int PB = 2;

  typedef logic [PB+$bits(aggr_par_meta_type)-1:0] exp_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NP-1:0]               in_empty;
  aggr_par_meta_type [NP-1:0]  in_data;
  logic [NP-1:0]               in_rd;
  logic                        out_full;
  logic                        out_wr;
  aggr_par_meta_type           out_data;
  logic [PB-1:0]               out_port;
  logic                        cfg_wr;
  logic                        cfg_rd;
  logic [PB:0]                 cfg_addr;
  logic [15:0]                 cfg_wdata;
  logic [15:0]                 cfg_rdata;

  aggr_par_meta_type src [NP][$];
  exp_t              exp_q [$];
  exp_t              mon_e;
  logic [NP-1:0]     pend_rd = '0;
  bit                mon_en = 1'b1;
  int                n_chk = 0;
  int                n_fail = 0;

  aggr_par_sched dut (
    .clk      (clk),
    .rst      (rst),
    .in_empty (in_empty),
    .in_data  (in_data),
    .in_rd    (in_rd),
    .out_full (out_full),
    .out_wr   (out_wr),
    .out_data (out_data),
    .out_port (out_port),
    .cfg_wr   (cfg_wr),
    .cfg_rd   (cfg_rd),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata)
  );

  always #5 clk = ~clk;

  function automatic aggr_par_meta_type mkw(
    int tag, int p, int k);
    logic [31:0] w;
    w = 32'hC000_0000 | (tag << 16) | (p << 8) | k;
    return w;
  endfunction

  function automatic void refresh();
    for (int p = 0; p < NP; p++) begin
      in_empty[p] = (src[p].size() == 0);
      in_data[p]  = in_empty[p] ? '0 : src[p][0];
    end
  endfunction

  function automatic void put(int tag, int p, int k,
                              bit expect_it);
    src[p].push_back(mkw(tag, p, k));
    if (expect_it)
      exp_q.push_back({PB'(p), mkw(tag, p, k)});
  endfunction

  // upstream FIFO model: pop what was granted last cycle
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++)
      if (pend_rd[p] && src[p].size() > 0)
        void'(src[p].pop_front());
    refresh();
  end

  // scoreboard: every downstream write must match in order
  always @(negedge clk) begin
    pend_rd = in_rd;
    if (mon_en && !rst && out_wr) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: port %0d data %h, none due",
                 out_port, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_port, out_data} !== mon_e) begin
          n_fail++;
          $display("FAIL sb_word: got %h, required %h",
                   {out_port, out_data}, mon_e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cfg_write(input logic [PB:0] a,
                           input logic [15:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_read(input logic [PB:0] a,
                          output logic [15:0] d);
    cfg_rd = 1'b1; cfg_addr = a;
    @(posedge clk); #1;
    cfg_rd = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic wait_drain(output int left);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); t++;
    end
    @(posedge clk); #1;
    left = exp_q.size();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (in_rd !== '0) begin n_fail++;
      $display("FAIL rst_in_rd: got %b, required 0", in_rd); end
    n_chk++;
    if (out_wr !== 1'b0) begin n_fail++;
      $display("FAIL rst_out_wr: got %b, required 0", out_wr); end
    n_chk++;
    if (out_data !== '0) begin n_fail++;
      $display("FAIL rst_out_data: got %h, required 0",
               out_data); end
    n_chk++;
    if (out_port !== '0) begin n_fail++;
      $display("FAIL rst_out_port: got %0d, required 0",
               out_port); end
    n_chk++;
    if (cfg_rdata !== '0) begin n_fail++;
      $display("FAIL rst_rdata: got %h, required 0",
               cfg_rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int left;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < NP; p++) put(1, p, k, 1'b1);
    refresh();
    @(negedge clk);
    n_chk++;
    if (in_rd !== 4'b0001) begin n_fail++;
      $display("FAIL rr_first_rd: got %b, required 0001",
               in_rd); end
    @(negedge clk);
    n_chk++;
    if (out_wr !== 1'b1 || out_port !== 2'd0) begin
      n_fail++;
      $display("FAIL rr_latency: wr %b port %0d, required 1 0",
               out_wr, out_port); end
    @(posedge clk); #1;
    wait_drain(left);
    n_chk++;
    if (left !== 0) begin n_fail++;
      $display("FAIL rr_drain: %0d left, required 0", left); end
  endtask

  task automatic test_weighted();
    int left;
    int k1;
    logic [15:0] s0, s1;
    cfg_write(3'b000, 16'd3);
    for (int p = 0; p < NP; p++)
      cfg_write({1'b1, PB'(p)}, 16'd0);
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) put(2, 0, 3 * r + j, 1'b1);
      for (int p = 1; p < NP; p++) put(2, p, r, 1'b1);
    end
    refresh();
    wait_drain(left);
    n_chk++;
    if (left !== 0) begin n_fail++;
      $display("FAIL wrr_drain: %0d left, required 0", left); end
    cfg_read(3'b100, s0);
    cfg_read(3'b101, s1);
    k1 = 3 * int'(s1);
    n_chk++;
    if (s0 !== 16'd12) begin n_fail++;
      $display("FAIL wrr_stat0: got %0d, required 12", s0); end
    n_chk++;
    if (s1 !== 16'd4 || int'(s0) != k1) begin n_fail++;
      $display("FAIL wrr_stat1: got %0d, required 4", s1); end
    cfg_write(3'b000, 16'd1);
  endtask

  task automatic test_back_to_back();
    int left;
    cfg_write(3'b010, 16'd2);
    for (int k = 0; k < 5; k++) put(3, 2, k, 1'b1);
    refresh();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (in_rd !== 4'b0100) begin n_fail++;
        $display("FAIL b2b_rd%0d: got %b, required 0100",
                 i, in_rd); end
    end
    @(negedge clk);
    n_chk++;
    if (in_rd !== 4'b0000) begin n_fail++;
      $display("FAIL b2b_idle: got %b, required 0000",
               in_rd); end
    @(posedge clk); #1;
    wait_drain(left);
    n_chk++;
    if (left !== 0) begin n_fail++;
      $display("FAIL b2b_drain: %0d left, required 0", left); end
  endtask

  task automatic test_stall();
    int left;
    cfg_write(3'b001, 16'd4);
    put(4, 3, 0, 1'b1);
    put(4, 1, 0, 1'b1);
    put(4, 1, 1, 1'b1);
    put(4, 1, 2, 1'b1);
    put(4, 1, 3, 1'b1);
    put(4, 3, 1, 1'b1);
    put(4, 1, 4, 1'b1);
    put(4, 1, 5, 1'b1);
    refresh();
    repeat (3) @(posedge clk);
    #1;
    out_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (in_rd !== '0) begin n_fail++;
        $display("FAIL stall_rd%0d: got %b, required 0",
                 i, in_rd); end
      if (i > 0) begin
        n_chk++;
        if (out_wr !== 1'b0) begin n_fail++;
          $display("FAIL stall_wr%0d: got %b, required 0",
                   i, out_wr); end
      end
    end
    @(posedge clk); #1;
    out_full = 1'b0;
    wait_drain(left);
    n_chk++;
    if (left !== 0) begin n_fail++;
      $display("FAIL stall_drain: %0d left, required 0",
               left); end
  endtask

  task automatic test_disable();
    int left;
    bit seen;
    cfg_write(3'b001, 16'd0);
    for (int k = 0; k < 3; k++) put(5, 1, k, 1'b0);
    put(5, 0, 0, 1'b1);
    put(5, 0, 1, 1'b1);
    refresh();
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (in_rd[1]) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0 || src[1].size() != 3) begin
      n_fail++;
      $display("FAIL dis_parked: popped %b, left %0d, req 0 3",
               seen, src[1].size()); end
    @(posedge clk); #1;
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++;
      $display("FAIL dis_others: %0d left, required 0",
               exp_q.size()); end
    for (int k = 0; k < 3; k++)
      exp_q.push_back({PB'(1), mkw(5, 1, k)});
    cfg_write(3'b001, 16'd1);
    @(negedge clk);
    n_chk++;
    if (in_rd !== 4'b0010) begin n_fail++;
      $display("FAIL dis_revive: got %b, required 0010",
               in_rd); end
    @(posedge clk); #1;
    wait_drain(left);
    n_chk++;
    if (left !== 0) begin n_fail++;
      $display("FAIL dis_drain: %0d left, required 0", left); end
  endtask

  task automatic test_cfg_collide();
    int left;
    logic [15:0] d;
    cfg_wr = 1'b1; cfg_rd = 1'b1;
    cfg_addr = 3'b010; cfg_wdata = 16'd5;
    @(posedge clk); #1;
    cfg_wr = 1'b0; cfg_rd = 1'b0;
    n_chk++;
    if (cfg_rdata !== 16'd2) begin n_fail++;
      $display("FAIL cfg_rw_old: got %0d, required 2",
               cfg_rdata); end
    cfg_read(3'b010, d);
    n_chk++;
    if (d !== 16'd5) begin n_fail++;
      $display("FAIL cfg_rw_new: got %0d, required 5", d); end
    put(6, 2, 0, 1'b1);
    refresh();
    cfg_wr = 1'b1; cfg_addr = 3'b110; cfg_wdata = 16'hFFFF;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    wait_drain(left);
    cfg_read(3'b110, d);
    n_chk++;
    if (d !== 16'd1 || left !== 0) begin n_fail++;
      $display("FAIL clr_pop: stat %0d left %0d, required 1 0",
               d, left); end
  endtask

  task automatic test_reset_mid();
    int left;
    logic [15:0] d;
    mon_en = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < NP; p++) put(7, p, k, 1'b0);
    refresh();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_chk++;
    if (in_rd !== '0 || out_wr !== 1'b0) begin n_fail++;
      $display("FAIL mid_rst_strobes: rd %b wr %b, required 0",
               in_rd, out_wr); end
    n_chk++;
    if (out_data !== '0 || out_port !== '0) begin n_fail++;
      $display("FAIL mid_rst_out: %h port %0d, required 0",
               out_data, out_port); end
    n_chk++;
    if (cfg_rdata !== '0) begin n_fail++;
      $display("FAIL mid_rst_rdata: got %h, required 0",
               cfg_rdata); end
    for (int p = 0; p < NP; p++) src[p].delete();
    refresh();
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    cfg_read(3'b010, d);
    n_chk++;
    if (d !== 16'd1) begin n_fail++;
      $display("FAIL mid_rst_wt2: got %0d, required 1", d); end
    cfg_read(3'b100, d);
    n_chk++;
    if (d !== 16'd0) begin n_fail++;
      $display("FAIL mid_rst_stat0: got %0d, required 0", d); end
    for (int p = 0; p < NP; p++) put(8, p, 0, 1'b1);
    refresh();
    @(negedge clk);
    n_chk++;
    if (in_rd !== 4'b0001) begin n_fail++;
      $display("FAIL mid_rst_first: got %b, required 0001",
               in_rd); end
    @(posedge clk); #1;
    wait_drain(left);
    n_chk++;
    if (left !== 0) begin n_fail++;
      $display("FAIL mid_rst_drain: %0d left, required 0",
               left); end
  endtask

  initial begin
    rst       = 1'b1;
    out_full  = 1'b0;
    cfg_wr    = 1'b0;
    cfg_rd    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    refresh();
    test_reset();
    test_round_robin();
    test_weighted();
    test_back_to_back();
    test_stall();
    test_disable();
    test_cfg_collide();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
